// File: rtl/router_fsm_nch.sv
// Packet-router control FSM with a programmable channel count.
// Decodes the header address, steers one packet into one of NUM_CH FIFOs and
// sequences the header, payload, parity and full-recovery phases. Packets with
// an out-of-range address, or stalled too long waiting for an empty FIFO, are
// dropped.
//
// Ports:
//   clk, resetn        clock (rising edge), synchronous active-low reset
//   packet_valid       source packet framing
//   addr_in            header address, valid with first packet_valid cycle
//   fifo_full          full flag of the selected FIFO
//   fifo_empty         per-channel empty flags
//   soft_reset         per-channel soft reset from FIFO read-timeout logic
//   parity_done        parity byte captured by register block
//   low_packet_valid   packet_valid fell while FIFO was full
//   detect_add .. drop_state   Moore state decodes
//   write_enb_reg      FIFO write enable phase
//   busy               stall source
//   wait_timeout       one-cycle pulse after a wait-for-empty timeout
//   sel_ch             latched destination channel
module router_fsm_nch #(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned WAIT_TIMEOUT = 32,
    parameter int unsigned CNT_W        = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy,
    output logic              drop_state,
    output logic              wait_timeout,
    output logic [ADDR_W-1:0] sel_ch
);

    localparam int unsigned CH_MAX  = 1 << ADDR_W;
    localparam int unsigned TO_LAST = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        ST_DECODE      = 4'd0,
        ST_LOAD_FIRST  = 4'd1,
        ST_LOAD_DATA   = 4'd2,
        ST_WAIT_EMPTY  = 4'd3,
        ST_LOAD_PARITY = 4'd4,
        ST_CHECK_PAR   = 4'd5,
        ST_FIFO_FULL   = 4'd6,
        ST_LOAD_AFTER  = 4'd7,
        ST_DROP        = 4'd8
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              timeout_c;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CH_MAX-1:0] empty_pad;
    logic [CH_MAX-1:0] sr_pad;
    logic              addr_ok;
    logic              sel_ok;
    logic              sr_hit;
    logic              to_hit;

    // Pad per-channel flags to the full address space so any address indexes safely.
    assign empty_pad = CH_MAX'(fifo_empty);
    assign sr_pad    = CH_MAX'(soft_reset);
    assign addr_ok   = ({1'b0, addr_in} < (ADDR_W+1)'(NUM_CH));
    assign sel_ok    = ({1'b0, sel_ch}  < (ADDR_W+1)'(NUM_CH));
    // Only the selected channel's soft reset matters, and never while decoding.
    assign sr_hit    = (state != ST_DECODE) && sel_ok && sr_pad[sel_ch];
    assign to_hit    = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_W'(TO_LAST));

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_DECODE;
        end else if (sr_hit) begin
            state <= ST_DECODE;
        end else begin
            state <= next_state;
        end
    end

    // Channel latch, wait counter and timeout pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sel_ch       <= '0;
            wait_cnt     <= '0;
            wait_timeout <= 1'b0;
        end else begin
            if (state == ST_DECODE) begin
                sel_ch <= addr_in;
            end
            // Cleared whenever outside WAIT_EMPTY, so every entry starts at zero; saturates.
            if (state == ST_WAIT_EMPTY && next_state == ST_WAIT_EMPTY && !sr_hit) begin
                wait_cnt <= (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            wait_timeout <= timeout_c && !sr_hit;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        timeout_c  = 1'b0;
        case (state)
            ST_DECODE: begin
                if (packet_valid) begin
                    if (!addr_ok)                next_state = ST_DROP;
                    else if (empty_pad[addr_in]) next_state = ST_LOAD_FIRST;
                    else                         next_state = ST_WAIT_EMPTY;
                end
            end
            ST_WAIT_EMPTY: begin
                if (empty_pad[sel_ch]) begin
                    next_state = ST_LOAD_FIRST;
                end else if (to_hit) begin
                    next_state = ST_DROP;
                    timeout_c  = 1'b1;
                end
            end
            ST_LOAD_FIRST:  next_state = ST_LOAD_DATA;
            ST_LOAD_DATA: begin
                if (fifo_full)          next_state = ST_FIFO_FULL;
                else if (!packet_valid) next_state = ST_LOAD_PARITY;
            end
            ST_FIFO_FULL: begin
                if (!fifo_full) next_state = ST_LOAD_AFTER;
            end
            ST_LOAD_AFTER: begin
                if (parity_done)           next_state = ST_DECODE;
                else if (low_packet_valid) next_state = ST_LOAD_PARITY;
                else                       next_state = ST_LOAD_DATA;
            end
            ST_LOAD_PARITY: next_state = ST_CHECK_PAR;
            ST_CHECK_PAR:   next_state = fifo_full ? ST_FIFO_FULL : ST_DECODE;
            ST_DROP: begin
                if (!packet_valid) next_state = ST_DECODE;
            end
            default:        next_state = ST_DECODE;
        endcase
    end

    // Moore output decode.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b0;
        drop_state    = 1'b0;
        case (state)
            ST_DECODE:      detect_add = 1'b1;
            ST_LOAD_FIRST: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            ST_LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_WAIT_EMPTY:  busy = 1'b1;
            ST_LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            ST_CHECK_PAR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            ST_FIFO_FULL: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            ST_LOAD_AFTER: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            ST_DROP:        drop_state = 1'b1;
            default:        ;
        endcase
    end

endmodule

// File: tb/tb_router_fsm_nch.sv
// Randomised and directed bench for router_fsm_nch with a queue-based scoreboard.
module tb_router_fsm_nch;

    localparam int unsigned NUM_CH       = 3;
    localparam int unsigned ADDR_W       = 2;
    localparam int unsigned WAIT_TIMEOUT = 4;
    localparam int unsigned CNT_W        = 6;

    logic              clk;
    logic              resetn;
    logic              packet_valid;
    logic [ADDR_W-1:0] addr_in;
    logic              fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_packet_valid;
    logic              detect_add, lfd_state, ld_state, full_state, laf_state;
    logic              rst_int_reg, write_enb_reg, busy, drop_state, wait_timeout;
    logic [ADDR_W-1:0] sel_ch;

    router_fsm_nch #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn), .packet_valid(packet_valid), .addr_in(addr_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
        .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .drop_state(drop_state),
        .wait_timeout(wait_timeout), .sel_ch(sel_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] dut_vec;
    assign dut_vec = {detect_add, lfd_state, ld_state, full_state, laf_state,
                      rst_int_reg, write_enb_reg, busy, drop_state, wait_timeout, sel_ch};

    // Reference model: packet phase, destination, cycles already spent waiting.
    localparam int PH_IDLE = 0, PH_FIRST = 1, PH_DATA = 2, PH_WAIT = 3, PH_PAR = 4,
                   PH_CHK = 5, PH_FULL = 6, PH_AFTER = 7, PH_DROP = 8;
    int m_phase  = PH_IDLE;
    int m_sel    = 0;
    int m_waited = 0;
    bit m_pulse  = 1'b0;

    logic [11:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic model_step();
        int nxt;
        bit pulse;
        int a;
        if (!resetn) begin
            m_phase = PH_IDLE; m_sel = 0; m_waited = 0; m_pulse = 1'b0;
            return;
        end
        nxt   = m_phase;
        pulse = 1'b0;
        a     = int'(addr_in);
        case (m_phase)
            PH_IDLE:  if (packet_valid) begin
                          if (a >= int'(NUM_CH))  nxt = PH_DROP;
                          else if (fifo_empty[a]) nxt = PH_FIRST;
                          else                    nxt = PH_WAIT;
                      end
            PH_WAIT:  if (fifo_empty[m_sel]) nxt = PH_FIRST;
                      else if (WAIT_TIMEOUT != 0 && m_waited + 1 == int'(WAIT_TIMEOUT)) begin
                          nxt = PH_DROP; pulse = 1'b1;
                      end
            PH_FIRST: nxt = PH_DATA;
            PH_DATA:  if (fifo_full) nxt = PH_FULL; else if (!packet_valid) nxt = PH_PAR;
            PH_FULL:  if (!fifo_full) nxt = PH_AFTER;
            PH_AFTER: nxt = parity_done ? PH_IDLE : (low_packet_valid ? PH_PAR : PH_DATA);
            PH_PAR:   nxt = PH_CHK;
            PH_CHK:   nxt = fifo_full ? PH_FULL : PH_IDLE;
            PH_DROP:  if (!packet_valid) nxt = PH_IDLE;
            default:  nxt = PH_IDLE;
        endcase
        if (m_phase != PH_IDLE && m_sel < int'(NUM_CH) && soft_reset[m_sel]) begin
            nxt = PH_IDLE; pulse = 1'b0;
        end
        if (m_phase == PH_IDLE) m_sel = a;
        if (m_phase == PH_WAIT && nxt == PH_WAIT) m_waited++;
        else m_waited = 0;
        m_phase = nxt;
        m_pulse = pulse;
    endtask

    function automatic logic [11:0] expect_vec();
        logic b;
        logic we;
        logic [1:0] s;
        b  = (m_phase == PH_FIRST || m_phase == PH_WAIT || m_phase == PH_PAR ||
              m_phase == PH_FULL  || m_phase == PH_AFTER || m_phase == PH_CHK);
        we = (m_phase == PH_DATA || m_phase == PH_PAR || m_phase == PH_AFTER);
        s  = 2'(m_sel);
        return {m_phase == PH_IDLE, m_phase == PH_FIRST, m_phase == PH_DATA,
                m_phase == PH_FULL, m_phase == PH_AFTER, m_phase == PH_CHK,
                we, b, m_phase == PH_DROP, m_pulse, s};
    endfunction

    // Drive one cycle of inputs away from the edge and queue the expected response.
    task automatic step(input bit rn, input bit pv, input logic [1:0] a, input logic [2:0] emp,
                        input bit ff, input logic [2:0] sr, input bit pd, input bit lpv);
        @(negedge clk);
        resetn = rn; packet_valid = pv; addr_in = a; fifo_empty = emp;
        fifo_full = ff; soft_reset = sr; parity_done = pd; low_packet_valid = lpv;
        model_step();
        exp_q.push_back(expect_vec());
    endtask

    // Monitor: compare DUT outputs against queued expectations after each edge.
    initial begin
        logic [11:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (dut_vec !== e) begin
                    miscompares++;
                    $display("FAIL outs t=%0t {da,lfd,ld,full,laf,rst,we,busy,drop,to,sel}: got %b required %b",
                             $time, dut_vec, e);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; packet_valid = 1'b0; addr_in = '0; fifo_full = 1'b0;
        fifo_empty = '0; soft_reset = '0; parity_done = 1'b0; low_packet_valid = 1'b0;

        // Reset, then a normal packet to channel 2.
        repeat (2) step(0, 0, 2'd0, 3'b000, 0, 3'b000, 0, 0);
        repeat (3) step(1, 1, 2'd2, 3'b111, 0, 3'b000, 0, 0);
        repeat (4) step(1, 0, 2'd0, 3'b111, 0, 3'b000, 0, 0);

        // Out-of-range address is dropped.
        repeat (5) step(1, 1, 2'd3, 3'b111, 0, 3'b000, 0, 0);
        repeat (2) step(1, 0, 2'd0, 3'b111, 0, 3'b000, 0, 0);

        // Wait-for-empty timeout.
        step(1, 1, 2'd1, 3'b101, 0, 3'b000, 0, 0);
        repeat (5) step(1, 1, 2'd0, 3'b101, 0, 3'b000, 0, 0);
        repeat (2) step(1, 0, 2'd0, 3'b101, 0, 3'b000, 0, 0);

        // Empty arrives in the same cycle the timeout would fire.
        step(1, 1, 2'd1, 3'b101, 0, 3'b000, 0, 0);
        repeat (3) step(1, 1, 2'd0, 3'b101, 0, 3'b000, 0, 0);
        repeat (2) step(1, 1, 2'd0, 3'b111, 0, 3'b000, 0, 0);
        repeat (4) step(1, 0, 2'd0, 3'b111, 0, 3'b000, 0, 0);

        // Full recovery on channel 0; parity_done beats low_packet_valid.
        repeat (2) step(1, 1, 2'd0, 3'b111, 0, 3'b000, 0, 0);
        repeat (3) step(1, 1, 2'd0, 3'b111, 1, 3'b000, 0, 0);
        step(1, 1, 2'd0, 3'b111, 0, 3'b000, 0, 0);
        step(1, 0, 2'd0, 3'b111, 0, 3'b000, 1, 1);
        step(1, 0, 2'd0, 3'b111, 0, 3'b000, 0, 0);

        // Soft reset on another channel is ignored; on the selected channel it aborts.
        repeat (2) step(1, 1, 2'd1, 3'b111, 0, 3'b000, 0, 0);
        step(1, 1, 2'd1, 3'b111, 0, 3'b001, 0, 0);
        step(1, 1, 2'd1, 3'b111, 0, 3'b010, 0, 0);
        step(1, 0, 2'd1, 3'b111, 0, 3'b000, 0, 0);

        // Reset in the middle of FIFO_FULL.
        repeat (2) step(1, 1, 2'd1, 3'b111, 0, 3'b000, 0, 0);
        repeat (2) step(1, 1, 2'd1, 3'b111, 1, 3'b000, 0, 0);
        step(0, 1, 2'd1, 3'b111, 1, 3'b000, 0, 0);
        step(1, 0, 2'd0, 3'b111, 0, 3'b000, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rn, pv, ff, pd, lpv;
            logic [1:0] a;
            logic [2:0] emp, sr;
            rn  = ($urandom_range(63) != 0);
            pv  = ($urandom_range(3) != 0);
            a   = 2'($urandom_range(3));
            emp = ($urandom_range(1) == 0) ? 3'($urandom) : 3'b000;
            ff  = ($urandom_range(4) == 0);
            sr  = ($urandom_range(15) == 0) ? 3'($urandom) : 3'b000;
            pd  = ($urandom_range(3) == 0);
            lpv = ($urandom_range(1) == 0);
            step(rn, pv, a, emp, ff, sr, pd, lpv);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
